// File: rtl/cwc_cap_pkg.sv
// Shared types and default sizing for the trigger-capture block.
package cwc_cap_pkg;

  localparam int unsigned CAP_DATA_W = 90;
  localparam int unsigned CAP_DEPTH  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } cap_state_e;

endpackage

// File: rtl/cwc_cap_ram.sv
// Sample buffer: simple dual-port RAM, one write port, one registered read port.
module cwc_cap_ram
  import cwc_cap_pkg::*;
#(
  parameter int unsigned DATA_W = CAP_DATA_W,
  parameter int unsigned DEPTH  = CAP_DEPTH,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Storage array is never reset; only the read register is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cwc_trig_capture.sv
// Masked-compare trigger capture with pre/post-trigger ring buffer and readout.
// probe_din is the debug-hub concatenation with probe0 in the MSBs.
module cwc_trig_capture
  import cwc_cap_pkg::*;
#(
  parameter int unsigned DATA_W = CAP_DATA_W,
  parameter int unsigned DEPTH  = CAP_DEPTH,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] probe_din,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [AW-1:0]     post_cnt,
  input  logic [AW-1:0]     rd_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              armed,
  output logic              triggered,
  output logic              done,
  output logic [AW-1:0]     trig_pos
);

  localparam int unsigned FW = AW + 1;
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

  cap_state_e    r_state, w_state_nxt;
  logic [AW-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [FW-1:0] r_fill, w_fill_nxt;
  logic [AW-1:0] r_trig_addr, w_trig_addr_nxt;
  logic [AW-1:0] r_post, w_post_nxt;
  logic [AW-1:0] r_trig_pos;
  logic          r_armed, r_triggered, r_done, r_rd_valid;
  logic          w_match, w_start, w_we, w_hit, w_rd_fire;
  logic [AW-1:0] w_oldest, w_oldest_nxt, w_rd_ptr;

  // arm/abort on a capturing cycle suppress that cycle's write and trigger.
  assign w_match      = ((probe_din ^ trig_value) & trig_mask) == '0;
  assign w_start      = arm & ~abort;
  assign w_we         = ((r_state == ST_ARMED) || (r_state == ST_POST)) & ~arm & ~abort;
  assign w_hit        = (r_state == ST_ARMED) & w_we & w_match;
  assign w_oldest     = (r_fill == FILL_FULL) ? r_wr_ptr : '0;
  assign w_oldest_nxt = (w_fill_nxt == FILL_FULL) ? w_wr_ptr_nxt : '0;
  assign w_rd_fire    = rd_en & (r_state == ST_DONE);
  assign w_rd_ptr     = w_oldest + rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_fill_nxt      = r_fill;
    w_trig_addr_nxt = r_trig_addr;
    w_post_nxt      = r_post;
    if (w_we) begin
      w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      if (r_fill != FILL_FULL) w_fill_nxt = r_fill + FW'(1);
    end
    case (r_state)
      ST_ARMED: begin
        if (w_hit) begin
          w_trig_addr_nxt = r_wr_ptr;
          w_post_nxt      = post_cnt;
          w_state_nxt     = (post_cnt == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (w_we) begin
          w_post_nxt = r_post - AW'(1);
          if (r_post == AW'(1)) w_state_nxt = ST_DONE;
        end
      end
      default: begin
      end
    endcase
    if (w_start) begin
      w_state_nxt  = ST_ARMED;
      w_wr_ptr_nxt = '0;
      w_fill_nxt   = '0;
    end
    if (abort) w_state_nxt = ST_IDLE;
  end

  // Status flags are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_trig_addr <= '0;
      r_post      <= '0;
      r_trig_pos  <= '0;
      r_armed     <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_fill      <= w_fill_nxt;
      r_trig_addr <= w_trig_addr_nxt;
      r_post      <= w_post_nxt;
      r_armed     <= (w_state_nxt == ST_ARMED);
      r_triggered <= (w_state_nxt == ST_POST);
      r_done      <= (w_state_nxt == ST_DONE);
      r_rd_valid  <= w_rd_fire;
      if ((w_state_nxt == ST_POST) || (w_state_nxt == ST_DONE))
        r_trig_pos <= w_trig_addr_nxt - w_oldest_nxt;
    end
  end

  cwc_cap_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (probe_din),
    .i_re    (w_rd_fire),
    .i_raddr (w_rd_ptr),
    .o_rdata (rd_data)
  );

  assign rd_valid  = r_rd_valid;
  assign armed     = r_armed;
  assign triggered = r_triggered;
  assign done      = r_done;
  assign trig_pos  = r_trig_pos;

endmodule

// File: tb/tb_cwc_trig_capture.sv
// Directed bench for cwc_trig_capture driving a free-running counter probe.
module tb_cwc_trig_capture;

  localparam int unsigned DATA_W = 90;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned AW     = 10;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] probe_din;
  logic              arm;
  logic              abort;
  logic [DATA_W-1:0] trig_mask;
  logic [DATA_W-1:0] trig_value;
  logic [AW-1:0]     post_cnt;
  logic [AW-1:0]     rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              armed;
  logic              triggered;
  logic              done;
  logic [AW-1:0]     trig_pos;

  int n_tests;
  int n_fail;

  cwc_trig_capture #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .probe_din  (probe_din),
    .arm        (arm),
    .abort      (abort),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .post_cnt   (post_cnt),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .armed      (armed),
    .triggered  (triggered),
    .done       (done),
    .trig_pos   (trig_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // One clock: outputs are sampled 1ns after the edge, then the probe counter advances.
  task automatic tick();
    @(posedge clk);
    #1;
    probe_din = probe_din + DATA_W'(1);
  endtask

  // Arm so that the first armed cycle presents count 0.
  task automatic start_capture(input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] v,
                               input logic [AW-1:0] p);
    trig_mask  = m;
    trig_value = v;
    post_cnt   = p;
    probe_din  = {DATA_W{1'b1}};
    arm        = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n;
    n = 0;
    while (!done && n < max_cycles) begin
      tick();
      n++;
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DATA_W-1:0] d, output logic v);
    rd_addr = a;
    rd_en   = 1'b1;
    tick();
    rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_tests++;
    if ({armed, triggered, done, rd_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_status: got %b required 0000", {armed, triggered, done, rd_valid});
    end
    n_tests++;
    if (trig_pos !== AW'(0)) begin
      n_fail++;
      $display("FAIL reset_trig_pos: got %0d required 0", trig_pos);
    end
    n_tests++;
    if (rd_data !== DATA_W'(0)) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %0d required 0", rd_data);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stay_idle: got armed=%b required 0", armed);
    end
  endtask

  task automatic test_basic();
    int t_trig;
    int t_done;
    logic [DATA_W-1:0] d;
    logic v;
    start_capture(DATA_W'(1), DATA_W'(1), AW'(8));
    n_tests++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_armed: got %b required 1", armed);
    end
    t_trig = -1;
    t_done = -1;
    for (int k = 1; k <= 40 && t_done < 0; k++) begin
      tick();
      if (triggered && t_trig < 0) t_trig = k;
      if (done) t_done = k;
    end
    // count 1 is presented after tick 1; triggered shows a cycle later, done 9 cycles after the trigger cycle
    n_tests++;
    if (t_trig !== 2) begin
      n_fail++;
      $display("FAIL basic_trig_cycle: got %0d required 2", t_trig);
    end
    n_tests++;
    if (t_done !== 10) begin
      n_fail++;
      $display("FAIL basic_done_cycle: got %0d required 10", t_done);
    end
    n_tests++;
    if (trig_pos !== AW'(1)) begin
      n_fail++;
      $display("FAIL basic_trig_pos: got %0d required 1", trig_pos);
    end
    do_read(AW'(9), d, v);
    n_tests++;
    if (v !== 1'b1 || d !== DATA_W'(9)) begin
      n_fail++;
      $display("FAIL basic_read9: got valid=%b data=%0d required valid=1 data=9", v, d);
    end
    tick();
    n_tests++;
    if (rd_valid !== 1'b0 || done !== 1'b1 || trig_pos !== AW'(1)) begin
      n_fail++;
      $display("FAIL basic_hold: got valid=%b done=%b pos=%0d required 0 1 1", rd_valid, done, trig_pos);
    end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] d;
    logic v;
    start_capture({DATA_W{1'b1}}, DATA_W'(2000), AW'(8));
    wait_done(3000);
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_done: got %b required 1", done);
    end
    // trigger at addr 976, last write addr 984, oldest addr 985 holds count 985
    n_tests++;
    if (trig_pos !== AW'(1015)) begin
      n_fail++;
      $display("FAIL wrap_trig_pos: got %0d required 1015", trig_pos);
    end
    do_read(AW'(0), d, v);
    n_tests++;
    if (v !== 1'b1 || d !== DATA_W'(985)) begin
      n_fail++;
      $display("FAIL wrap_read0: got valid=%b data=%0d required valid=1 data=985", v, d);
    end
    do_read(AW'(1015), d, v);
    n_tests++;
    if (d !== DATA_W'(2000)) begin
      n_fail++;
      $display("FAIL wrap_read_trig: got %0d required 2000", d);
    end
    do_read(AW'(1023), d, v);
    n_tests++;
    if (d !== DATA_W'(2008)) begin
      n_fail++;
      $display("FAIL wrap_read_last: got %0d required 2008", d);
    end
  endtask

  task automatic test_rearm();
    logic [DATA_W-1:0] d;
    logic v;
    start_capture({DATA_W{1'b1}}, DATA_W'(1), AW'(1));
    n_tests++;
    if (armed !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rearm_state: got armed=%b done=%b required 1 0", armed, done);
    end
    repeat (2) tick();
    n_tests++;
    if (triggered !== 1'b1 || trig_pos !== AW'(1)) begin
      n_fail++;
      $display("FAIL rearm_new_trig: got trig=%b pos=%0d required 1 1", triggered, trig_pos);
    end
    wait_done(10);
    n_tests++;
    if (done !== 1'b1 || trig_pos !== AW'(1)) begin
      n_fail++;
      $display("FAIL rearm_done: got done=%b pos=%0d required 1 1", done, trig_pos);
    end
    do_read(AW'(0), d, v);
    n_tests++;
    if (v !== 1'b1 || d !== DATA_W'(0)) begin
      n_fail++;
      $display("FAIL rearm_read0: got valid=%b data=%0d required valid=1 data=0", v, d);
    end
  endtask

  task automatic test_post_zero();
    logic [DATA_W-1:0] d;
    logic v;
    start_capture(DATA_W'(0), DATA_W'(0), AW'(0));
    n_tests++;
    if (armed !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL post0_armed: got armed=%b done=%b required 1 0", armed, done);
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || triggered !== 1'b0 || trig_pos !== AW'(0)) begin
      n_fail++;
      $display("FAIL post0_done: got done=%b trig=%b pos=%0d required 1 0 0", done, triggered, trig_pos);
    end
    do_read(AW'(0), d, v);
    n_tests++;
    if (v !== 1'b1 || d !== DATA_W'(0)) begin
      n_fail++;
      $display("FAIL post0_read0: got valid=%b data=%0d required valid=1 data=0", v, d);
    end
  endtask

  task automatic test_overwrite();
    logic [DATA_W-1:0] d;
    logic v;
    // trigger at addr 5, post samples wrap to addr 4, so the trigger sample is the oldest
    start_capture({DATA_W{1'b1}}, DATA_W'(5), AW'(1023));
    wait_done(2000);
    n_tests++;
    if (done !== 1'b1 || trig_pos !== AW'(0)) begin
      n_fail++;
      $display("FAIL ovw_trig_pos: got done=%b pos=%0d required 1 0", done, trig_pos);
    end
    do_read(AW'(0), d, v);
    n_tests++;
    if (d !== DATA_W'(5)) begin
      n_fail++;
      $display("FAIL ovw_read0: got %0d required 5", d);
    end
    do_read(AW'(1023), d, v);
    n_tests++;
    if (d !== DATA_W'(1028)) begin
      n_fail++;
      $display("FAIL ovw_read_last: got %0d required 1028", d);
    end
  endtask

  task automatic test_abort_trigger();
    logic seen_done;
    start_capture({DATA_W{1'b1}}, DATA_W'(5), AW'(3));
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if ({armed, triggered, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_idle: got %b required 000", {armed, triggered, done});
    end
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    n_tests++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %b required 0", seen_done);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_rd_valid: got %b required 0", rd_valid);
    end
  endtask

  task automatic test_reset_in_post();
    start_capture({DATA_W{1'b1}}, DATA_W'(3), AW'(20));
    repeat (4) tick();
    n_tests++;
    if (triggered !== 1'b1 || trig_pos !== AW'(3)) begin
      n_fail++;
      $display("FAIL rstpost_in_post: got trig=%b pos=%0d required 1 3", triggered, trig_pos);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({armed, triggered, done, rd_valid} !== 4'b0000 || trig_pos !== AW'(0)) begin
      n_fail++;
      $display("FAIL rstpost_async: got %b pos=%0d required 0000 pos=0",
               {armed, triggered, done, rd_valid}, trig_pos);
    end
    #2;
    rst_n = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({armed, triggered, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstpost_idle: got %b required 000", {armed, triggered, done});
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstpost_rd_valid: got %b required 0", rd_valid);
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    probe_din  = '0;
    arm        = 1'b0;
    abort      = 1'b0;
    trig_mask  = '0;
    trig_value = '0;
    post_cnt   = '0;
    rd_addr    = '0;
    rd_en      = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_rearm();
    test_post_zero();
    test_overwrite();
    test_abort_trigger();
    test_reset_in_post();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
